// File: rtl/virtual_button_decoder.sv
// rtl/virtual_button_decoder.sv - debounced press decoder to change/enter/cancel pulses; auto-repeat under VBD_AUTOREPEAT_EN
module virtual_button_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] number,
    input  logic       control,
    output logic       button0,
    output logic       button1,
    output logic       button2,
    output logic       invalid,
    output logic [4:0] value
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef VBD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ctl_meta_q, ctl_meta_d;
    logic             ctl_s_q, ctl_s_d;
    logic [4:0]       num_meta_q, num_meta_d;
    logic [4:0]       num_s_q, num_s_d;
    logic [4:0]       value_q, value_d;
    logic             button0_q, button0_d;
    logic             button1_q, button1_d;
    logic             button2_q, button2_d;
    logic             invalid_q, invalid_d;
`ifdef VBD_AUTOREPEAT_EN
    // Set once the first repeat has fired, so later ones use the shorter period.
    logic             rep_q, rep_d;
`endif

    always_comb begin
        ctl_meta_d = control;
        ctl_s_d    = ctl_meta_q;
        num_meta_d = number;
        num_s_d    = num_meta_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        button0_d = 1'b0;
        button1_d = 1'b1 & 1'b0;
        button2_d = 1'b0;
        invalid_d = 1'b0;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef VBD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif

        case (state_q)
            IDLE: begin
                if (ctl_s_q) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!ctl_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    value_d = num_s_q;
`ifdef VBD_AUTOREPEAT_EN
                    rep_d   = 1'b0;
`endif
                    case (num_s_q)
                        5'd0:    button0_d = 1'b1;
                        5'd1:    button1_d = 1'b1;
                        5'd2:    button2_d = 1'b1;
                        default: invalid_d = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!ctl_s_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef VBD_AUTOREPEAT_EN
                else if (value_q == 5'd0) begin
                    if ((!rep_q && cnt_q == RD_LAST) || (rep_q && cnt_q == RP_LAST)) begin
                        button0_d = 1'b1;
                        cnt_d     = '0;
                        rep_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
            end
            RELEASE: begin
                if (ctl_s_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ctl_meta_q <= 1'b0;
            ctl_s_q    <= 1'b0;
            num_meta_q <= '0;
            num_s_q    <= '0;
            value_q    <= '0;
            button0_q  <= 1'b0;
            button1_q  <= 1'b0;
            button2_q  <= 1'b0;
            invalid_q  <= 1'b0;
`ifdef VBD_AUTOREPEAT_EN
            rep_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctl_meta_q <= ctl_meta_d;
            ctl_s_q    <= ctl_s_d;
            num_meta_q <= num_meta_d;
            num_s_q    <= num_s_d;
            value_q    <= value_d;
            button0_q  <= button0_d;
            button1_q  <= button1_d;
            button2_q  <= button2_d;
            invalid_q  <= invalid_d;
`ifdef VBD_AUTOREPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign button0 = button0_q;
    assign button1 = button1_q;
    assign button2 = button2_q;
    assign invalid = invalid_q;
    assign value   = value_q;

endmodule

// File: tb/tb_virtual_button_decoder.sv
// tb/tb_virtual_button_decoder.sv - directed bench for virtual_button_decoder with D=4
module tb_virtual_button_decoder;

    localparam int D   = 4;
    localparam int ACC = D + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] number = 5'd0;
    logic       control = 1'b0;
    logic       button0, button1, button2, invalid;
    logic [4:0] value;
    logic [3:0] pv;

    int checks = 0;
    int failures = 0;

    virtual_button_decoder #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (64),
        .REPEAT_PERIOD  (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .number (number),
        .control(control),
        .button0(button0),
        .button1(button1),
        .button2(button2),
        .invalid(invalid),
        .value  (value)
    );

    always #5 clk = ~clk;

    assign pv = {invalid, button2, button1, button0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] accept_vec(input logic [4:0] n);
        case (n)
            5'd0:    return 4'b0001;
            5'd1:    return 4'b0010;
            5'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(tag, {28'd0, pv}, 32'd0);
        end
    endtask

    task automatic press_hold(input logic [4:0] n, input int hold, input string tag);
        logic [3:0] exp;
        number  = n;
        control = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            exp = (i == ACC) ? accept_vec(n) : 4'b0000;
`ifdef VBD_AUTOREPEAT_EN
            if (n == 5'd0 && i >= ACC + 64 && ((i - ACC - 64) % 16) == 0)
                exp = 4'b0001;
`endif
            chk(tag, {28'd0, pv}, {28'd0, exp});
        end
        chk({tag, "_value"}, {27'd0, value}, {27'd0, n});
        control = 1'b0;
        idle_check({tag, "_release"}, 12);
    endtask

    initial begin
        logic [15:0] bounce;

        #3 rst_n = 1'b0;
        #1;
        chk("reset_pulses", {28'd0, pv}, 32'd0);
        chk("reset_value", {27'd0, value}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_reset", 4);

        press_hold(5'd1, 27, "clean_enter");

        bounce = 16'b0000_0000_0011_0011;
        for (int i = 0; i < 16; i++) begin
            control = bounce[i];
            @(negedge clk);
            chk("press_bounce", {28'd0, pv}, 32'd0);
        end
        control = 1'b0;
        idle_check("press_bounce_tail", 6);

        number  = 5'd2;
        control = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("cancel_press", {28'd0, pv}, (i == ACC) ? 32'd4 : 32'd0);
        end
        bounce = 16'b0000_0000_0111_1100;
        for (int i = 0; i < 8; i++) begin
            control = bounce[i];
            @(negedge clk);
            chk("release_bounce", {28'd0, pv}, 32'd0);
        end
        control = 1'b0;
        idle_check("release_bounce_tail", 12);
        chk("cancel_value", {27'd0, value}, 32'd2);

        press_hold(5'd7, 10, "invalid_sel");

        number  = 5'd0;
        control = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) number = 5'd1;
            chk("num_change", {28'd0, pv}, (i == ACC) ? 32'd2 : 32'd0);
        end
        chk("num_change_value", {27'd0, value}, 32'd1);
        control = 1'b0;
        idle_check("num_change_release", 12);

        number  = 5'd2;
        control = 1'b1;
        idle_check("pre_reset_press", 4);
        #2 rst_n = 1'b0;
        #1;
        chk("midpress_reset_pulses", {28'd0, pv}, 32'd0);
        chk("midpress_reset_value", {27'd0, value}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("after_reset_press", {28'd0, pv}, (i == ACC) ? 32'd4 : 32'd0);
        end
        control = 1'b0;
        idle_check("after_reset_release", 12);

        press_hold(5'd0, ACC + 120, "hold_change");
        press_hold(5'd1, ACC + 120, "hold_enter");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
